// File: rtl/panel_bus_pkg.sv
// panel_bus_pkg: shared definitions for the panel byte-stream to Avalon-MM master.
// Holds the FSM state encoding, command byte layout and default sizing constants.
package panel_bus_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GETDATA = 2'd1,
        ST_BUS     = 2'd2,
        ST_SEND    = 2'd3
    } state_t;

    // Command byte: bit 7 selects read (1) or write (0)
    localparam int CMD_RD = 7;

    // Default word geometry and bus watchdog length
    localparam int NBYTES_DEF  = 4;
    localparam int DATA_W_DEF  = 8 * NBYTES_DEF;
    localparam int TIMEOUT_DEF = 1024;

    // True when every bit between the address field and the read flag is zero
    function automatic logic cmd_pad_ok(input logic [7:0] b, input int addr_w);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i >= addr_w && b[i]) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/panel_bus_byteser.sv
// panel_bus_byteser: NBYTES-wide word register with a byte cursor.
// Gathers bytes LSB first into the word (push) and scatters the word back out
// LSB first (pop). A parallel load replaces the whole word and rewinds the cursor.
module panel_bus_byteser
    import panel_bus_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_clr,
    input  logic                  i_load,
    input  logic [8*NBYTES-1:0]   i_load_word,
    input  logic                  i_push,
    input  logic [7:0]            i_push_byte,
    input  logic                  i_pop,
    output logic [8*NBYTES-1:0]   o_word,
    output logic [7:0]            o_byte,
    output logic                  o_last
);

    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [CW-1:0]        r_cnt;
    logic [8*NBYTES-1:0]  r_word;
    logic [CW-1:0]        w_cnt_next;

    assign o_last     = (r_cnt == CW'(NBYTES - 1));
    assign w_cnt_next = o_last ? '0 : r_cnt + CW'(1);
    assign o_word     = r_word;
    assign o_byte     = r_word[8*r_cnt +: 8];

    // Word storage and byte cursor; load wins over rewind, rewind over push/pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (i_load) begin
            r_word <= i_load_word;
            r_cnt  <= '0;
        end else if (i_clr) begin
            r_cnt  <= '0;
        end else if (i_push) begin
            r_word[8*r_cnt +: 8] <= i_push_byte;
            r_cnt                <= w_cnt_next;
        end else if (i_pop) begin
            r_cnt  <= w_cnt_next;
        end
    end

endmodule

// File: rtl/panel_bus_master.sv
// panel_bus_master: host byte stream to Avalon-MM master bridge.
// One command byte (bit7 read/write, low bits address) per bus access; writes
// carry NBYTES data bytes LSB first, reads return NBYTES bytes LSB first.
// Optional bus watchdog: define PANEL_BUS_MASTER_TIMEOUT_EN.
module panel_bus_master
    import panel_bus_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int NBYTES  = NBYTES_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [ADDR_W-1:0]     m_address,
    output logic                  m_write,
    output logic                  m_read,
    output logic [8*NBYTES-1:0]   m_writedata,
    input  logic [8*NBYTES-1:0]   m_readdata,
    input  logic                  m_waitrequest,
    output logic                  busy,
    output logic                  err
);

    localparam int DATA_W = 8 * NBYTES;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ADDR_W-1:0]    r_m_address;
    logic                 r_m_read;
    logic                 r_m_write;
    logic                 r_err;

    logic                 w_rx_fire;
    logic                 w_cmd_ok;
    logic                 w_timeout;
    logic                 w_ser_clr;
    logic                 w_ser_load;
    logic [DATA_W-1:0]    w_ser_load_word;
    logic                 w_ser_push;
    logic                 w_ser_pop;
    logic [DATA_W-1:0]    w_ser_word;
    logic [7:0]           w_ser_byte;
    logic                 w_ser_last;
    logic                 w_set_rd;
    logic                 w_set_wr;
    logic                 w_strobe_clr;
    logic                 w_addr_ld;
    logic                 w_err_set;

    assign rx_ready    = (r_state == ST_IDLE) || (r_state == ST_GETDATA);
    assign tx_valid    = (r_state == ST_SEND);
    assign tx_data     = (r_state == ST_SEND) ? w_ser_byte : 8'h00;
    assign busy        = (r_state != ST_IDLE);
    assign err         = r_err;
    assign m_address   = r_m_address;
    assign m_read      = r_m_read;
    assign m_write     = r_m_write;
    assign m_writedata = w_ser_word;

    assign w_rx_fire = rx_valid && rx_ready;
    assign w_cmd_ok  = cmd_pad_ok(rx_data, ADDR_W);

`ifdef PANEL_BUS_MASTER_TIMEOUT_EN
    logic [15:0] r_to_cnt;

    assign w_timeout = (r_state == ST_BUS) && m_waitrequest &&
                       (r_to_cnt == 16'(TIMEOUT - 1));

    // Count consecutive stalled cycles of the current bus access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_to_cnt <= '0;
        end else if ((r_state == ST_BUS) && m_waitrequest && !w_timeout) begin
            r_to_cnt <= r_to_cnt + 16'd1;
        end else begin
            r_to_cnt <= '0;
        end
    end
`else
    // No watchdog in this build; TIMEOUT stays in the parameter list so both
    // builds instantiate identically
    assign w_timeout = 1'b0 && (TIMEOUT != 0);
`endif

    // Shared gather/scatter word: write data in, read data out
    panel_bus_byteser #(
        .NBYTES (NBYTES)
    ) u_ser (
        .clk         (clk),
        .reset       (reset),
        .i_clr       (w_ser_clr),
        .i_load      (w_ser_load),
        .i_load_word (w_ser_load_word),
        .i_push      (w_ser_push),
        .i_push_byte (rx_data),
        .i_pop       (w_ser_pop),
        .o_word      (w_ser_word),
        .o_byte      (w_ser_byte),
        .o_last      (w_ser_last)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-cycle control pulses
    always_comb begin
        w_state_nxt     = r_state;
        w_ser_clr       = 1'b0;
        w_ser_load      = 1'b0;
        w_ser_load_word = m_readdata;
        w_ser_push      = 1'b0;
        w_ser_pop       = 1'b0;
        w_set_rd        = 1'b0;
        w_set_wr        = 1'b0;
        w_strobe_clr    = 1'b0;
        w_addr_ld       = 1'b0;
        w_err_set       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_rx_fire) begin
                    if (!w_cmd_ok) begin
                        // Malformed command is swallowed; stay idle
                        w_err_set = 1'b1;
                    end else begin
                        w_addr_ld = 1'b1;
                        if (rx_data[CMD_RD]) begin
                            w_set_rd    = 1'b1;
                            w_state_nxt = ST_BUS;
                        end else begin
                            w_ser_clr   = 1'b1;
                            w_state_nxt = ST_GETDATA;
                        end
                    end
                end
            end

            ST_GETDATA: begin
                if (w_rx_fire) begin
                    w_ser_push = 1'b1;
                    if (w_ser_last) begin
                        w_set_wr    = 1'b1;
                        w_state_nxt = ST_BUS;
                    end
                end
            end

            ST_BUS: begin
                // The strobe is high for the whole of BUS, so completion is
                // simply the first cycle without a stall
                if (!m_waitrequest) begin
                    w_strobe_clr = 1'b1;
                    if (r_m_read) begin
                        w_ser_load  = 1'b1;
                        w_state_nxt = ST_SEND;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_timeout) begin
                    w_strobe_clr = 1'b1;
                    w_err_set    = 1'b1;
                    if (r_m_read) begin
                        w_ser_load      = 1'b1;
                        w_ser_load_word = '1;
                        w_state_nxt     = ST_SEND;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end

            ST_SEND: begin
                if (tx_ready) begin
                    w_ser_pop = 1'b1;
                    if (w_ser_last) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Bus strobes: raised on entry to BUS, dropped when the access ends
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_m_read  <= 1'b0;
            r_m_write <= 1'b0;
        end else if (w_strobe_clr) begin
            r_m_read  <= 1'b0;
            r_m_write <= 1'b0;
        end else begin
            if (w_set_rd) begin
                r_m_read <= 1'b1;
            end
            if (w_set_wr) begin
                r_m_write <= 1'b1;
            end
        end
    end

    // Address latch, loaded from each well-formed command byte
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_m_address <= '0;
        end else if (w_addr_ld) begin
            r_m_address <= rx_data[ADDR_W-1:0];
        end
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end

endmodule
